// File: rtl/keypad_code_fifo.sv
// Key-code FIFO between keypad scanner and consumer.
// Edge-detects key_valid, first-word fall-through read, sticky overflow.
module keypad_code_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    key_code,
    input  logic          key_valid,
    input  logic          rd_ready,
    input  logic          clr_overflow,
    output logic          rd_valid,
    output logic [3:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          key_valid_q;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          drop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr];

    assign push  = key_valid && !key_valid_q;
    assign pop   = rd_valid && rd_ready;
    // A full FIFO still accepts a push when a pop frees a slot the same cycle
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            key_valid_q <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
            if (wr_en) begin
                mem[wr_ptr] <= key_code;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_code_fifo.sv
// Directed self-checking bench for keypad_code_fifo (DEPTH=8).
module tb_keypad_code_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] key_code;
    logic       key_valid;
    logic       rd_ready;
    logic       clr_overflow;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    keypad_code_fifo #(.DEPTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .key_code(key_code),
        .key_valid(key_valid),
        .rd_ready(rd_ready),
        .clr_overflow(clr_overflow),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        key_code     = 4'h0;
        key_valid    = 1'b0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        key_valid = 1'b1;
        key_code  = 4'h3;
        #1;
        chk("push_not_yet_visible", 32'(empty), 1);
        tick();
        key_valid = 1'b0;
        tick();
        chk("p1_count", 32'(count), 1);
        chk("p1_data", 32'(rd_data), 3);
        push(4'hA);
        push(4'hF);
        chk("p3_count", 32'(count), 3);
        rd_ready = 1'b1;
        chk("rd0_data", 32'(rd_data), 4'h3);
        tick();
        chk("rd1_data", 32'(rd_data), 4'hA);
        chk("rd1_count", 32'(count), 2);
        tick();
        chk("rd2_data", 32'(rd_data), 4'hF);
        chk("rd2_count", 32'(count), 1);
        tick();
        chk("drain_count", 32'(count), 0);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_rd_valid", 32'(rd_valid), 0);
        tick();
        chk("rd_empty_count", 32'(count), 0);
        rd_ready = 1'b0;

        key_valid = 1'b1;
        key_code  = 4'h5;
        repeat (10) tick();
        key_valid = 1'b0;
        tick();
        chk("hold_count", 32'(count), 1);
        chk("hold_data", 32'(rd_data), 5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("hold_pop_empty", 32'(empty), 1);

        for (int i = 0; i < 9; i++) push(4'(i));
        chk("ovf_full", 32'(full), 1);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_rd%0d", i), 32'(rd_data), i);
            tick();
        end
        rd_ready = 1'b0;
        chk("ovf_drained", 32'(empty), 1);

        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_alone", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) push(4'(i + 1));
        chk("refill_full", 32'(full), 1);
        key_valid    = 1'b1;
        key_code     = 4'h9;
        clr_overflow = 1'b1;
        tick();
        key_valid    = 1'b0;
        clr_overflow = 1'b0;
        chk("clr_vs_drop", 32'(overflow), 1);
        tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_again", 32'(overflow), 0);

        key_valid = 1'b1;
        key_code  = 4'hE;
        rd_ready  = 1'b1;
        tick();
        key_valid = 1'b0;
        rd_ready  = 1'b0;
        chk("pp_count", 32'(count), 8);
        chk("pp_overflow", 32'(overflow), 0);
        chk("pp_head", 32'(rd_data), 2);
        tick();
        rd_ready = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk($sformatf("pp_rd%0d", i), 32'(rd_data), i);
            tick();
        end
        chk("pp_last", 32'(rd_data), 4'hE);
        tick();
        rd_ready = 1'b0;
        chk("pp_empty", 32'(empty), 1);

        for (int i = 0; i < 4; i++) push(4'(i + 10));
        chk("mid_count", 32'(count), 4);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_rd_valid", 32'(rd_valid), 0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        push(4'hC);
        chk("post_rst_data", 32'(rd_data), 4'hC);
        chk("post_rst_count", 32'(count), 1);

        reset     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h6;
        tick();
        reset = 1'b0;
        tick();
        key_valid = 1'b0;
        chk("kv_at_release_count", 32'(count), 1);
        chk("kv_at_release_data", 32'(rd_data), 6);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_code_fifo.md
KEYPAD_CODE_FIFO -- requirements
Module: keypad_code_fifo

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of stored key codes; legal values are powers of two from 2 to 16.
REQ-002 Parameter CW, default log2(DEPTH)+1, SHALL set the width of the occupancy count.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 key_code  input  4  SHALL carry the hex key code (0-15) from the keypad scanner.
REQ-006 key_valid  input  1  SHALL qualify key_code; it is high for one or more cycles per key press.
REQ-007 rd_ready  input  1  SHALL indicate that the consumer accepts rd_data this cycle.
REQ-008 clr_overflow  input  1  SHALL clear the sticky overflow flag.
REQ-009 rd_valid  output  1  SHALL indicate that rd_data holds the oldest stored code.
REQ-010 rd_data  output  4  SHALL be the oldest stored code (first-word fall-through).
REQ-011 count  output  CW  SHALL be the number of stored codes, 0..DEPTH.
REQ-012 full  output  1  SHALL be high exactly when count == DEPTH.
REQ-013 empty  output  1  SHALL be high exactly when count == 0.
REQ-014 overflow  output  1  SHALL be a sticky flag indicating that a key event was dropped.

Function
REQ-015 The block SHALL register key_valid and detect its rising edge; a push event is key_valid=1 while the registered copy is 0.
REQ-016 A key_valid held high for N cycles SHALL produce exactly one push event.
REQ-017 On a push event the block SHALL write key_code, sampled in that same cycle, at the write pointer.
REQ-018 A pop event SHALL be rd_valid && rd_ready; on a pop the read pointer advances by one.
REQ-019 rd_valid SHALL equal !empty; rd_data SHALL equal mem[rd_ptr] combinationally, with no extra read latency.
REQ-020 Write and read pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-021 count SHALL be a register: +1 on push only, -1 on pop only, unchanged on push with pop or on neither.
REQ-022 Push when not full: the code SHALL be stored and visible on rd_data no earlier than the next cycle.
REQ-023 Push when full with no pop in the same cycle: the code SHALL be dropped, storage and pointers SHALL be unchanged, and overflow SHALL be set on the next edge.
REQ-024 Push when full with a pop in the same cycle: both SHALL complete, count SHALL stay DEPTH, and overflow SHALL NOT be set.
REQ-025 Push when empty: a pop cannot occur in the same cycle because rd_valid=0; the new code appears the next cycle.
REQ-026 rd_ready while empty SHALL have no effect; the pointers SHALL NOT move.
REQ-027 clr_overflow=1 SHALL clear overflow on the next edge, unless a drop occurs in the same cycle; set SHALL win.
REQ-028 The contents of rd_data while empty SHALL be don't-care, but SHALL NOT contain X after reset (memory reset to 0).

Reset
REQ-029 On reset the block SHALL asynchronously set both pointers to 0, count=0, the registered key_valid to 0, overflow=0 and all memory entries to 0.
REQ-030 After reset: empty=1, full=0 and rd_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored codes immediately, without waiting for a clock edge.
REQ-032 A key_valid already high when reset deasserts SHALL count as a push event on the first clock edge.

Verification
REQ-033 Three 1-cycle key_valid pulses with codes 0x3, 0xA, 0xF, then rd_ready held high -> rd_data reads 3, A, F in order, count goes 3->0, then empty=1.
REQ-034 key_valid held high for 10 cycles with code 0x5 -> count=1, and a single pop returns 5.
REQ-035 Nine pushes (codes 0..8, DEPTH=8) with no reads -> full=1, count=8, overflow=1, and reads return 0..7; code 8 is lost.
REQ-036 FIFO full and a push coincides with a pop -> count stays 8, overflow stays 0, and the last code read is the newly pushed one.
REQ-037 overflow=1, then clr_overflow pulsed alone -> overflow=0 next cycle; clr_overflow in the same cycle as a drop -> overflow stays 1.
REQ-038 Reset asserted with 4 codes stored -> count=0 and empty=1 immediately; after release, a push of 0xC is read back as C.
